mem_bank: RTL and testbench
===========================

MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 8, address port width in bits.
REQ-003 Parameter DEPTH, default 64, number of words; valid addresses 0..DEPTH-1.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all sequential logic.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 memread  input  1  read enable, sampled at the rising clk edge.
REQ-008 memwrite  input  1  write enable, sampled at the rising clk edge.
REQ-009 address  input  ADDR_W  word address shared by read and write.
REQ-010 writedata  input  DATA_W  write data.
REQ-011 readdata  output  DATA_W  registered read data.
REQ-012 addr_err  output  1  registered flag; 1 when the last enabled access was out of range.

Function
REQ-013 Storage SHALL be DEPTH words of DATA_W bits; entry i SHALL hold i*10 (truncated to DATA_W) after reset.
REQ-014 Read: at a rising edge with memread=1 and address<DEPTH, readdata SHALL load mem[address]; latency is one clock.
REQ-015 With memread=0, readdata SHALL hold its previous value.
REQ-016 Write: at a rising edge with memwrite=1 and address<DEPTH, mem[address] SHALL load writedata.
REQ-017 Read and write at the same edge and address SHALL return the old contents (read-before-write); the new value is visible on the next read.
REQ-018 Out of range: an enabled read with address>=DEPTH SHALL load readdata with 0; an enabled write with address>=DEPTH SHALL leave memory unchanged.
REQ-019 addr_err SHALL update only at edges where memread or memwrite is 1: it becomes 1 for an out-of-range address and 0 for an in-range address. It holds at other edges.
REQ-020 Addresses SHALL NOT wrap or alias: for example, 64 does not map to entry 0.
REQ-021 Address, writedata and enable values between clock edges SHALL have no effect on outputs.

Reset
REQ-022 While rst_n=0, readdata SHALL be 0 and addr_err SHALL be 0, independent of clk.
REQ-023 Reset SHALL re-initialize every entry i to i*10, discarding prior writes.
REQ-024 An edge that coincides with rst_n=0 SHALL perform no read or write.
REQ-025 After rst_n deasserts, the first rising edge SHALL operate normally.
REQ-026 Asserting reset in the middle of an access sequence SHALL immediately clear the outputs; the interrupted access has no effect.

Verification
REQ-027 Reset, then memread=1 with address 0, 1, 5, 63 on successive edges -> readdata 0, 10, 50, 630, each one clock after its address; addr_err=0.
REQ-028 memread=1 with address 64, then 127, then 255 -> readdata=0 and addr_err=1; then address 2 -> readdata=20 and addr_err=0.
REQ-029 Read address 7 (readdata=70), then memread=0 with address sweeping 8..20 -> readdata stays 70.
REQ-030 Write 0xDEADBEEF to address 10 with memread=1 at the same edge -> readdata=100; the next read of 10 -> 0xDEADBEEF; a write to 200 -> addr_err=1 and no entry changes.
REQ-031 Write 0x12345678 to address 3, then pulse rst_n low between edges -> readdata=0 immediately; the next read of 3 -> 30.
REQ-032 Sweep address 0..127 with memread=1 every edge -> readdata=10*address for 0..63; readdata=0 with addr_err=1 for 64..127.

Source files
------------

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - single-port word memory with registered read data and range-error flag
// Storage is initialized to i*10 on reset; out-of-range accesses read as 0 and never write.
module mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              addr_err_q, addr_err_d;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // Full-width compare so that addresses past DEPTH never alias onto low entries.
  assign in_range = (32'(address) < 32'(DEPTH));
  assign idx      = IDX_W'(address);

  always_comb begin
    readdata_d = readdata_q;
    addr_err_d = addr_err_q;
    if (memread) begin
      readdata_d = in_range ? mem_q[idx] : '0;
    end
    if (memread || memwrite) begin
      addr_err_d = !in_range;
    end
  end

  // Read data is taken from mem_q before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i * 10);
      end
    end else if (memwrite && in_range) begin
      mem_q[idx] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign readdata = readdata_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_bank.sv
// tb/tb_mem_bank.sv - table-driven and scoreboarded checks of mem_bank
module tb_mem_bank;

  logic        clk;
  logic        rst_n;
  logic        memread;
  logic        memwrite;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] erd;
    logic        eerr;
    string       nm;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];

  mem_bank #(.DATA_W(32), .ADDR_W(8), .DEPTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".readdata"}, readdata, e.erd);
      chk({e.nm, ".addr_err"}, {31'b0, addr_err}, {31'b0, e.eerr});
    end
  endtask

  task automatic step(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input string nm);
    exp_t e;
    @(negedge clk);
    memread   = rd;
    memwrite  = wr;
    address   = a;
    writedata = wd;
    e.erd  = erd;
    e.eerr = eerr;
    e.nm   = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'd0,   32'h0,        32'd0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd1,   32'h0,        32'd10,       1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'd5,   32'h0,        32'd50,       1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'd63,  32'h0,        32'd630,      1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'd64,  32'h0,        32'd0,        1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'd127, 32'h0,        32'd0,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'd255, 32'h0,        32'd0,        1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'd3,   32'h0,        32'd0,        1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'd2,   32'h0,        32'd20,       1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'd7,   32'h0,        32'd70,       1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'd10,  32'hDEADBEEF, 32'd100,      1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'd10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'd200, 32'h55AA55AA, 32'hDEADBEEF, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'd8,   32'h0,        32'd80,       1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'd136, 32'h0,        32'd0,        1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'd10,  32'h0,        32'hDEADBEEF, 1'b0};

    rst_n     = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    address   = 8'd0;
    writedata = 32'd0;
    #3;
    chk("reset.readdata", readdata, 32'd0);
    chk("reset.addr_err", {31'b0, addr_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].erd, vecs[i].eerr,
           $sformatf("vec%0d", i));
    end
    step(vecs[9].rd, vecs[9].wr, vecs[9].addr, vecs[9].wd, vecs[9].erd, vecs[9].eerr, "vec9");
    for (int a = 8; a <= 20; a++) begin
      step(1'b0, 1'b0, 8'(a), 32'hFFFF_FFFF, 32'd70, 1'b0, $sformatf("hold%0d", a));
    end
    for (int i = 10; i < 16; i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].erd, vecs[i].eerr,
           $sformatf("vec%0d", i));
    end

    step(1'b0, 1'b1, 8'd3, 32'h12345678, 32'hDEADBEEF, 1'b0, "wr3");
    @(negedge clk);
    memwrite = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("pulse.readdata", readdata, 32'd0);
    chk("pulse.addr_err", {31'b0, addr_err}, 32'd0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'd3, 32'h0, 32'd30, 1'b0, "rd3_after_reset");
    step(1'b1, 1'b0, 8'd10, 32'h0, 32'd100, 1'b0, "rd10_after_reset");

    @(negedge clk);
    rst_n     = 1'b0;
    memread   = 1'b1;
    memwrite  = 1'b1;
    address   = 8'd4;
    writedata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk("edge_in_reset.readdata", readdata, 32'd0);
    chk("edge_in_reset.addr_err", {31'b0, addr_err}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    memwrite = 1'b0;
    step(1'b1, 1'b0, 8'd4, 32'h0, 32'd40, 1'b0, "rd4_first_edge");

    for (int a = 0; a < 128; a++) begin
      step(1'b1, 1'b0, 8'(a), 32'h0, (a < 64) ? 32'(a * 10) : 32'd0, (a >= 64),
           $sformatf("sweep%0d", a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
